// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Drives the PC register's stall / jump controls. Merges redirect sources
//   (trap unit, EX-stage branch, post-reset boot vector) with stall sources
//   (load-use hazard, instruction-memory wait), sequences trap entry through
//   a fixed drain period, and emits the matching IF/ID and ID/EX flushes.
//
// Parameters:
//   ADDR_W        address width
//   RESET_VECTOR  address issued as the first jump after reset
//   DRAIN_CYCLES  cycles spent draining before the trap redirect (1..15)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   branch_req/branch_target   EX-stage taken branch pulse and destination
//   trap_req/trap_vector       trap pulse and handler address
//   hazard_stall               load-use hazard, hold PC
//   imem_ready                 instruction memory accepts a fetch
//   pc_stall                   hold PC
//   pc_jump_enable             load pc_jump_address into PC
//   pc_jump_address            redirect target (zero when not jumping)
//   flush_if_id, flush_id_ex   pipeline squash strobes
//   seq_state                  state encoding (debug)
//
// Optional feature (define FETCH_SEQ_PERF_EN):
//   perf_stall_cycles  cycles with pc_stall=1 outside BOOT
//   perf_redirects     pc_jump_enable pulses, boot jump excluded
// All outputs are registered.

module fetch_sequencer #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vector,
  input  logic              hazard_stall,
  input  logic              imem_ready,
  output logic              pc_stall,
  output logic              pc_jump_enable,
  output logic [ADDR_W-1:0] pc_jump_address,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        seq_state
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_redirects
`endif
);

  localparam logic [1:0] BOOT       = 2'd0;
  localparam logic [1:0] RUN        = 2'd1;
  localparam logic [1:0] WAIT_MEM   = 2'd2;
  localparam logic [1:0] TRAP_DRAIN = 2'd3;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_vld_q, pend_vld_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              jump_q, jump_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fif_q, fif_d;
  logic              fex_q, fex_d;

  // A trap arriving during the drain replaces the vector immediately, so the
  // redirect issued on that same cycle already uses the newer address.
  logic [ADDR_W-1:0] trap_addr;
  assign trap_addr = trap_req ? trap_vector : pend_addr_q;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_vld_d  = pend_vld_q;
    cnt_d       = cnt_q;
    stall_d     = 1'b0;
    jump_d      = 1'b0;
    addr_d      = '0;
    fif_d       = 1'b0;
    fex_d       = 1'b0;

    case (state_q)
      BOOT: begin
        jump_d  = 1'b1;
        addr_d  = RESET_VECTOR;
        state_d = RUN;
      end

      // RUN and WAIT_MEM share one decision tree: WAIT_MEM only differs by
      // holding a pending branch and by not looking at hazard_stall.
      RUN, WAIT_MEM: begin
        if (trap_req) begin
          pend_addr_d = trap_vector;
          pend_vld_d  = 1'b0;
          cnt_d       = DRAIN_INIT;
          state_d     = TRAP_DRAIN;
          stall_d     = 1'b1;
          fif_d       = 1'b1;
          fex_d       = 1'b1;
        end else if (pend_vld_q) begin
          // younger branches are already squashed; ignore them
          if (imem_ready) begin
            jump_d     = 1'b1;
            addr_d     = pend_addr_q;
            pend_vld_d = 1'b0;
            state_d    = RUN;
          end else begin
            stall_d = 1'b1;
          end
        end else if (branch_req) begin
          fif_d = 1'b1;
          fex_d = 1'b1;
          if (imem_ready) begin
            jump_d  = 1'b1;
            addr_d  = branch_target;
            state_d = RUN;
          end else begin
            pend_addr_d = branch_target;
            pend_vld_d  = 1'b1;
            stall_d     = 1'b1;
            state_d     = WAIT_MEM;
          end
        end else if (!imem_ready) begin
          stall_d = 1'b1;
          state_d = WAIT_MEM;
        end else if (hazard_stall && state_q == RUN) begin
          stall_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      default: begin // TRAP_DRAIN
        if (trap_req) pend_addr_d = trap_vector;
        if (cnt_q == 4'd1 && imem_ready) begin
          jump_d  = 1'b1;
          addr_d  = trap_addr;
          fif_d   = 1'b1;
          fex_d   = 1'b1;
          state_d = RUN;
        end else begin
          stall_d = 1'b1;
          fif_d   = 1'b1;
          if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pend_addr_q <= '0;
      pend_vld_q  <= 1'b0;
      cnt_q       <= '0;
      stall_q     <= 1'b1;
      jump_q      <= 1'b0;
      addr_q      <= '0;
      fif_q       <= 1'b0;
      fex_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_vld_q  <= pend_vld_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      jump_q      <= jump_d;
      addr_q      <= addr_d;
      fif_q       <= fif_d;
      fex_q       <= fex_d;
    end
  end

  assign pc_stall        = stall_q;
  assign pc_jump_enable  = jump_q;
  assign pc_jump_address = addr_q;
  assign flush_if_id     = fif_q;
  assign flush_id_ex     = fex_q;
  assign seq_state       = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_redir_q;

  // Counted from the next-output values so each count lines up with the
  // registered output it describes. stall_d is never set from BOOT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (stall_d) perf_stall_q <= perf_stall_q + 32'd1;
      if (jump_d && state_q != BOOT) perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_req = 1'b0;
  logic [31:0] branch_target = '0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        hazard_stall = 1'b0;
  logic        imem_ready = 1'b1;

  logic        pc_stall, pc_jump_enable, flush_if_id, flush_id_ex;
  logic [31:0] pc_jump_address;
  logic [1:0]  seq_state;

  fetch_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (RV),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_req      (branch_req),
    .branch_target   (branch_target),
    .trap_req        (trap_req),
    .trap_vector     (trap_vector),
    .hazard_stall    (hazard_stall),
    .imem_ready      (imem_ready),
    .pc_stall        (pc_stall),
    .pc_jump_enable  (pc_jump_enable),
    .pc_jump_address (pc_jump_address),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .seq_state       (seq_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a few plain facts about the sequencer rather than a
  // state register. booting = reset seen, boot jump not yet issued.
  bit          m_boot = 1'b1;
  int          m_trap_left = 0;   // >0 while draining toward a trap redirect
  logic [31:0] m_trap_vec = '0;
  logic [31:0] m_pend[$];         // branch waiting on instruction memory
  bit          m_wait = 1'b0;     // fetch blocked on instruction memory

  logic        e_stall = 1'b1, e_jump = 1'b0, e_fif = 1'b0, e_fex = 1'b0;
  logic [31:0] e_addr = '0;
  logic [1:0]  e_state = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] a, input bit flush);
    e_jump = 1'b1;
    e_addr = a;
    e_fif  = flush;
    e_fex  = flush;
  endtask

  task automatic model_step();
    e_stall = 1'b0; e_jump = 1'b0; e_addr = '0; e_fif = 1'b0; e_fex = 1'b0;
    if (!rst_n) begin
      m_boot = 1'b1; m_trap_left = 0; m_pend.delete(); m_wait = 1'b0;
      e_stall = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
      redirect(RV, 1'b0);
    end else if (m_trap_left > 0) begin
      if (trap_req) m_trap_vec = trap_vector;
      if (m_trap_left == 1 && imem_ready) begin
        redirect(m_trap_vec, 1'b1);
        m_trap_left = 0;
        m_wait = 1'b0;
      end else begin
        e_stall = 1'b1;
        e_fif   = 1'b1;
        if (m_trap_left > 1) m_trap_left--;
      end
    end else if (trap_req) begin
      m_trap_left = DRAIN;
      m_trap_vec  = trap_vector;
      m_pend.delete();
      m_wait  = 1'b0;
      e_stall = 1'b1; e_fif = 1'b1; e_fex = 1'b1;
    end else if (m_pend.size() > 0) begin
      if (imem_ready) begin
        redirect(m_pend.pop_front(), 1'b0);
        m_wait = 1'b0;
      end else e_stall = 1'b1;
    end else if (branch_req) begin
      if (imem_ready) begin
        redirect(branch_target, 1'b1);
        m_wait = 1'b0;
      end else begin
        m_pend.push_back(branch_target);
        m_wait = 1'b1;
        e_stall = 1'b1; e_fif = 1'b1; e_fex = 1'b1;
      end
    end else if (!imem_ready) begin
      e_stall = 1'b1;
      m_wait  = 1'b1;
    end else if (m_wait) begin
      m_wait = 1'b0;
    end else if (hazard_stall) begin
      e_stall = 1'b1;
    end
    e_state = m_boot ? 2'd0 : (m_trap_left > 0) ? 2'd3 : m_wait ? 2'd2 : 2'd1;
  endtask

  task automatic compare_all();
    check("pc_stall",        {31'd0, pc_stall},       {31'd0, e_stall});
    check("pc_jump_enable",  {31'd0, pc_jump_enable}, {31'd0, e_jump});
    check("pc_jump_address", pc_jump_address,         e_addr);
    check("flush_if_id",     {31'd0, flush_if_id},    {31'd0, e_fif});
    check("flush_id_ex",     {31'd0, flush_id_ex},    {31'd0, e_fex});
    check("seq_state",       {30'd0, seq_state},      {30'd0, e_state});
    check("stall_jump_excl", {31'd0, pc_stall & pc_jump_enable}, 32'd0);
  endtask

  task automatic drive(input bit r, input bit br, input logic [31:0] bt,
                       input bit tr, input logic [31:0] tv, input bit hz, input bit rdy);
    rst_n = r; branch_req = br; branch_target = bt; trap_req = tr;
    trap_vector = tv; hazard_stall = hz; imem_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  initial begin
    // reset
    drive(1'b0, 0, 0, 0, 0, 0, 1);
    drive(1'b0, 0, 0, 0, 0, 0, 1);
    check("lit_reset_stall", {31'd0, pc_stall}, 32'd1);
    check("lit_reset_state", {30'd0, seq_state}, 32'd0);

    // boot jump then quiet RUN
    idle(1);
    check("lit_boot_jump", {31'd0, pc_jump_enable}, 32'd1);
    check("lit_boot_addr", pc_jump_address, 32'h100);
    check("lit_boot_stall", {31'd0, pc_stall}, 32'd0);
    idle(1);
    check("lit_run_state", {30'd0, seq_state}, 32'd1);
    check("lit_run_quiet", {27'd0, pc_stall, pc_jump_enable, flush_if_id, flush_id_ex, 1'b0}, 32'd0);

    // branch with memory ready
    drive(1, 1, 32'h40, 0, 0, 0, 1);
    check("lit_br_addr", pc_jump_address, 32'h40);
    check("lit_br_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    idle(1);
    check("lit_br_after", {31'd0, pc_jump_enable}, 32'd0);

    // branch while memory busy; second branch ignored
    drive(1, 1, 32'h80, 0, 0, 0, 0);
    check("lit_wm_stall", {31'd0, pc_stall}, 32'd1);
    drive(1, 1, 32'hC0, 0, 0, 0, 0);
    check("lit_wm_noflush", {31'd0, flush_if_id}, 32'd0);
    idle(0);
    idle(1);
    check("lit_wm_addr", pc_jump_address, 32'h80);

    // trap with simultaneous branch
    drive(1, 1, 32'h40, 1, 32'h200, 0, 1);
    idle(1);
    check("lit_drain_stall", {31'd0, pc_stall}, 32'd1);
    idle(1);
    check("lit_trap_addr", pc_jump_address, 32'h200);
    check("lit_trap_jump", {31'd0, pc_jump_enable}, 32'd1);
    idle(1);

    // hazard for two cycles
    drive(1, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1, 1);
    check("lit_hz_stall", {31'd0, pc_stall}, 32'd1);
    idle(1);
    check("lit_hz_release", {31'd0, pc_stall}, 32'd0);

    // reset in the middle of a trap drain
    drive(1, 0, 0, 1, 32'h300, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("lit_rst_state", {30'd0, seq_state}, 32'd0);
    idle(1);
    check("lit_rst_boot_addr", pc_jump_address, 32'h100);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 4) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom_range(0, 11) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
